bht_ctrl: RTL and testbench

Access controller for the bimodal branch history table. It arbitrates the table's single access port between fetch-stage lookups and resolve-stage counter updates, buffering updates in a small FIFO with an anti-starvation age counter. It also sequences a per-domain flush walk on privilege-domain switch. It sits between the fetch/resolve pipelines and the BHT array.

---
 rtl/bht_ctrl.sv | 339 +++++++++++++++++++++++++++++++++
 tb/tb_bht_ctrl.sv | 350 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bht_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : bht_ctrl
// Purpose  : Access controller for the bimodal branch history table. Shares
//            the table's single access port between fetch-stage lookups and
//            resolve-stage counter updates. Updates are buffered in a small
//            in-order FIFO with an anti-starvation age counter. A per-domain
//            flush walk clears the table on a privilege-domain switch.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Build option:
//   BHT_CTRL_FLUSH_EN - compiles in the flush FSM, the domain-filtered FIFO
//                       drop and the walk index counter. When undefined,
//                       flush_done_o is a registered copy of flush_req_i,
//                       no clears are issued and the FIFO is never filtered.
// ----------------------------------------------------------------------------
// Ports:
//   clk_i, rst_ni        clock, asynchronous active-low reset
//   lkp_*                fetch lookup request / grant / registered response
//   upd_*                resolve update request, accepted into the FIFO
//   flush_*              single-cycle flush request, busy flag, done pulse
//   bht_*                array port: req/we/clr, index, bank, direction,
//                        target (combinational from FIFO head, walk index
//                        and the lookup inputs)
// ============================================================================

package bht_ctrl_pkg;
    typedef enum logic [1:0] {
        DOM_INIT = 2'd0,
        DOM_PRIV = 2'd1,
        DOM_USER = 2'd2
    } domain_t;
endpackage

`ifndef BHT_IDX_WIDTH
`define BHT_IDX_WIDTH 4
`endif

module bht_ctrl
    import bht_ctrl_pkg::*;
#(
    parameter int IDX_W   = `BHT_IDX_WIDTH,
    parameter int QDEPTH  = 4,
    parameter int AGE_MAX = 7
) (
    input  logic             clk_i,
    input  logic             rst_ni,

    input  logic             lkp_valid_i,
    input  logic [IDX_W-1:0] lkp_idx_i,
    input  domain_t          lkp_domain_i,
    output logic             lkp_ready_o,
    output logic             lkp_rsp_valid_o,

    input  logic             upd_valid_i,
    output logic             upd_ready_o,
    input  logic [IDX_W-1:0] upd_idx_i,
    input  logic             upd_taken_i,
    input  logic [31:0]      upd_targ_i,
    input  domain_t          upd_domain_i,

    input  logic             flush_req_i,
    input  domain_t          flush_domain_i,
    output logic             flush_busy_o,
    output logic             flush_done_o,

    output logic             bht_req_o,
    output logic             bht_we_o,
    output logic             bht_clr_o,
    output logic [IDX_W-1:0] bht_idx_o,
    output domain_t          bht_domain_o,
    output logic             bht_taken_o,
    output logic [31:0]      bht_targ_o
);

    localparam int c_CNT_W = $clog2(QDEPTH + 1);
    localparam int c_PTR_W = $clog2(QDEPTH);
    localparam int c_AGE_W = (AGE_MAX < 1) ? 1 : $clog2(AGE_MAX + 1);
    localparam logic [c_AGE_W-1:0] c_AGE_LIM = c_AGE_W'(AGE_MAX);
    localparam logic [c_CNT_W-1:0] c_FULL    = c_CNT_W'(QDEPTH);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WALK = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    typedef struct packed {
        logic [IDX_W-1:0] idx;
        logic             taken;
        logic [31:0]      targ;
        domain_t          domain;
    } upd_entry_t;

    // ------------------------------------------------------------------
    // Update FIFO storage: a shift-register queue, head always at slot 0,
    // so that the flush filter can compact survivors in order.
    // ------------------------------------------------------------------
    upd_entry_t           r_fifo [QDEPTH];
    logic [c_CNT_W-1:0]   r_cnt;
    logic [c_AGE_W-1:0]   r_age;
    logic                 r_rsp_valid;

    upd_entry_t           w_fifo_nxt [QDEPTH];
    upd_entry_t           w_mid      [QDEPTH];
    logic [QDEPTH-1:0]    w_vld;
    logic [QDEPTH-1:0]    w_keep;
    logic [c_PTR_W-1:0]   w_pos;
    logic [c_CNT_W-1:0]   w_cnt_nxt;
    logic [c_CNT_W-1:0]   w_cnt_deq;
    logic [c_CNT_W-1:0]   w_cnt_enq;
    upd_entry_t           w_upd_entry;
    upd_entry_t           w_head;

    logic                 w_full;
    logic                 w_empty;
    logic                 w_force_drain;
    logic                 w_drain;
    logic                 w_lkp_grant;
    logic                 w_enq;

    // Flush-side signals, driven by whichever configuration is built.
    state_t               w_state;
    logic                 w_flush_start;
    logic                 w_busy;
    logic                 w_done;
    logic [IDX_W-1:0]     w_clr_idx;
    domain_t              w_clr_dom;

    assign w_full  = (r_cnt == c_FULL);
    assign w_empty = (r_cnt == '0);
    assign w_head  = r_fifo[0];

    assign w_upd_entry = '{idx: upd_idx_i, taken: upd_taken_i,
                           targ: upd_targ_i, domain: upd_domain_i};

    // ------------------------------------------------------------------
    // Arbitration: a full FIFO or an aged head beats a lookup; otherwise
    // lookups win and the FIFO drains only into idle cycles.
    // ------------------------------------------------------------------
    assign w_force_drain = !w_empty && (w_full || (r_age == c_AGE_LIM));
    assign w_lkp_grant   = (w_state == ST_IDLE) && lkp_valid_i && !w_force_drain;
    assign w_drain       = (w_state == ST_IDLE) && !w_empty &&
                           (w_force_drain || !lkp_valid_i);

    // No bypass when full: a same-cycle dequeue does not open a slot.
    assign upd_ready_o = !w_full && (w_state == ST_IDLE);
    assign w_enq       = upd_valid_i && upd_ready_o;
    assign lkp_ready_o = w_lkp_grant;

    assign w_cnt_deq = r_cnt - c_CNT_W'(w_drain);
    assign w_cnt_enq = w_cnt_deq + c_CNT_W'(w_enq);

    // Next FIFO contents: dequeue shift, then enqueue at the tail, then drop
    // entries of the domain being flushed and compact the survivors.
    always_comb begin
        for (int i = 0; i < QDEPTH; i++) begin
            w_mid[i] = r_fifo[i];
            if (w_drain) begin
                w_mid[i] = (i == QDEPTH - 1) ? '0 : r_fifo[(i + 1) % QDEPTH];
            end
            if (w_enq && (c_CNT_W'(i) == w_cnt_deq)) begin
                w_mid[i] = w_upd_entry;
            end
            w_vld[i]  = (c_CNT_W'(i) < w_cnt_enq);
            w_keep[i] = w_vld[i] &&
                        !(w_flush_start && (w_mid[i].domain == flush_domain_i));
        end

        w_pos     = '0;
        w_cnt_nxt = '0;
        for (int k = 0; k < QDEPTH; k++) begin
            w_fifo_nxt[k] = '0;
        end
        for (int i = 0; i < QDEPTH; i++) begin
            if (w_keep[i]) begin
                w_fifo_nxt[w_pos] = w_mid[i];
                w_pos             = w_pos + 1'b1;
                w_cnt_nxt         = w_cnt_nxt + 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < QDEPTH; i++) begin
                r_fifo[i] <= '0;
            end
            r_cnt <= '0;
        end else begin
            r_fifo <= w_fifo_nxt;
            r_cnt  <= w_cnt_nxt;
        end
    end

    // Age of the head: counts cycles the head waits, saturating at the limit
    // that forces a drain; restarts with every new head.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_age <= '0;
        end else if (w_empty || w_drain) begin
            r_age <= '0;
        end else if (r_age != c_AGE_LIM) begin
            r_age <= r_age + 1'b1;
        end
    end

    // The array returns read data one cycle after the access.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_rsp_valid <= 1'b0;
        end else begin
            r_rsp_valid <= w_lkp_grant;
        end
    end
    assign lkp_rsp_valid_o = r_rsp_valid;

`ifdef BHT_CTRL_FLUSH_EN
    // ------------------------------------------------------------------
    // Flush FSM: IDLE -> WALK (one clear per index) -> DONE -> IDLE.
    // ------------------------------------------------------------------
    state_t           r_state;
    state_t           w_state_nxt;
    logic [IDX_W-1:0] r_widx;
    logic [IDX_W-1:0] w_widx_nxt;
    domain_t          r_fdom;
    domain_t          w_fdom_nxt;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state <= ST_IDLE;
            r_widx  <= '0;
            r_fdom  <= DOM_INIT;
        end else begin
            r_state <= w_state_nxt;
            r_widx  <= w_widx_nxt;
            r_fdom  <= w_fdom_nxt;
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_widx_nxt    = r_widx;
        w_fdom_nxt    = r_fdom;
        w_flush_start = 1'b0;
        w_busy        = 1'b0;
        w_done        = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (flush_req_i) begin
                    if ((flush_domain_i == DOM_PRIV) || (flush_domain_i == DOM_USER)) begin
                        w_state_nxt   = ST_WALK;
                        w_flush_start = 1'b1;
                        w_widx_nxt    = '0;
                        w_fdom_nxt    = flush_domain_i;
                    end else begin
                        // Nothing to clear: acknowledge straight away.
                        w_state_nxt = ST_DONE;
                    end
                end
            end
            ST_WALK: begin
                w_busy     = 1'b1;
                w_widx_nxt = r_widx + 1'b1;
                if (r_widx == '1) begin
                    w_state_nxt = ST_DONE;
                end
            end
            ST_DONE: begin
                w_done      = 1'b1;
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    assign w_state   = r_state;
    assign w_clr_idx = r_widx;
    assign w_clr_dom = r_fdom;
`else
    // Flush support not built: acknowledge every request one cycle later so
    // that requesters never wait forever.
    logic r_done;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_done <= 1'b0;
        end else begin
            r_done <= flush_req_i;
        end
    end

    assign w_state       = ST_IDLE;
    assign w_flush_start = 1'b0;
    assign w_busy        = 1'b0;
    assign w_done        = r_done;
    assign w_clr_idx     = '0;
    assign w_clr_dom     = DOM_INIT;
`endif

    assign flush_busy_o = w_busy;
    assign flush_done_o = w_done;

    // ------------------------------------------------------------------
    // Array port mux: walk clear, FIFO drain, or lookup read.
    // ------------------------------------------------------------------
    always_comb begin
        bht_req_o    = 1'b0;
        bht_we_o     = 1'b0;
        bht_clr_o    = 1'b0;
        bht_idx_o    = '0;
        bht_domain_o = DOM_INIT;
        bht_taken_o  = 1'b0;
        bht_targ_o   = '0;
        if (w_state == ST_WALK) begin
            bht_req_o    = 1'b1;
            bht_we_o     = 1'b1;
            bht_clr_o    = 1'b1;
            bht_idx_o    = w_clr_idx;
            bht_domain_o = w_clr_dom;
        end else if (w_drain) begin
            bht_req_o    = 1'b1;
            bht_we_o     = 1'b1;
            bht_idx_o    = w_head.idx;
            bht_domain_o = w_head.domain;
            bht_taken_o  = w_head.taken;
            bht_targ_o   = w_head.targ;
        end else if (w_lkp_grant) begin
            bht_req_o    = 1'b1;
            bht_idx_o    = lkp_idx_i;
            bht_domain_o = lkp_domain_i;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_bht_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_bht_ctrl
// Purpose  : Self-checking bench for bht_ctrl. Directed stimulus pushes the
//            hand-computed array accesses into a scoreboard queue; a monitor
//            on the falling clock edge pops and compares every access the
//            DUT presents. Handshake and flush flags are checked inline.
// Revision : 1.0 - initial release
// ============================================================================
module tb_bht_ctrl;
    import bht_ctrl_pkg::*;

    localparam int IDX_W = 4;

    typedef struct packed {
        logic             we;
        logic             clr;
        logic [IDX_W-1:0] idx;
        logic [1:0]       dom;
        logic             taken;
        logic [31:0]      targ;
    } acc_t;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             lkp_valid;
    logic [IDX_W-1:0] lkp_idx;
    domain_t          lkp_dom;
    logic             lkp_ready;
    logic             lkp_rsp_valid;
    logic             upd_valid;
    logic             upd_ready;
    logic [IDX_W-1:0] upd_idx;
    logic             upd_taken;
    logic [31:0]      upd_targ;
    domain_t          upd_dom;
    logic             flush_req;
    domain_t          flush_dom;
    logic             flush_busy;
    logic             flush_done;
    logic             bht_req;
    logic             bht_we;
    logic             bht_clr;
    logic [IDX_W-1:0] bht_idx;
    domain_t          bht_dom;
    logic             bht_taken;
    logic [31:0]      bht_targ;

    acc_t exp_q[$];
    acc_t mon_act;
    acc_t mon_exp;
    int   n_checks = 0;
    int   n_fail   = 0;
    logic seen_flag;

    bht_ctrl #(.IDX_W(IDX_W), .QDEPTH(4), .AGE_MAX(7)) dut (
        .clk_i           (clk),
        .rst_ni          (rst_n),
        .lkp_valid_i     (lkp_valid),
        .lkp_idx_i       (lkp_idx),
        .lkp_domain_i    (lkp_dom),
        .lkp_ready_o     (lkp_ready),
        .lkp_rsp_valid_o (lkp_rsp_valid),
        .upd_valid_i     (upd_valid),
        .upd_ready_o     (upd_ready),
        .upd_idx_i       (upd_idx),
        .upd_taken_i     (upd_taken),
        .upd_targ_i      (upd_targ),
        .upd_domain_i    (upd_dom),
        .flush_req_i     (flush_req),
        .flush_domain_i  (flush_dom),
        .flush_busy_o    (flush_busy),
        .flush_done_o    (flush_done),
        .bht_req_o       (bht_req),
        .bht_we_o        (bht_we),
        .bht_clr_o       (bht_clr),
        .bht_idx_o       (bht_idx),
        .bht_domain_o    (bht_dom),
        .bht_taken_o     (bht_taken),
        .bht_targ_o      (bht_targ)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic void exp_rd(input logic [IDX_W-1:0] idx, input domain_t d);
        exp_q.push_back({1'b0, 1'b0, idx, d, 1'b0, 32'h0});
    endfunction

    function automatic void exp_wr(input logic [IDX_W-1:0] idx, input domain_t d,
                                   input logic taken, input logic [31:0] targ);
        exp_q.push_back({1'b1, 1'b0, idx, d, taken, targ});
    endfunction

    function automatic void exp_clr(input logic [IDX_W-1:0] idx, input domain_t d);
        exp_q.push_back({1'b1, 1'b1, idx, d, 1'b0, 32'h0});
    endfunction

    task automatic set_idle();
        lkp_valid = 1'b0; lkp_idx = '0; lkp_dom = DOM_INIT;
        upd_valid = 1'b0; upd_idx = '0; upd_taken = 1'b0; upd_targ = '0; upd_dom = DOM_INIT;
        flush_req = 1'b0; flush_dom = DOM_INIT;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic set_upd(input logic [IDX_W-1:0] idx, input logic taken,
                           input logic [31:0] targ, input domain_t d);
        upd_valid = 1'b1; upd_idx = idx; upd_taken = taken; upd_targ = targ; upd_dom = d;
    endtask

    task automatic set_lkp(input logic [IDX_W-1:0] idx, input domain_t d);
        lkp_valid = 1'b1; lkp_idx = idx; lkp_dom = d;
    endtask

    // Scoreboard monitor: every array access must match the next expectation.
    always @(negedge clk) begin
        if (bht_req) begin
            mon_act = {bht_we, bht_clr, bht_idx, bht_dom, bht_taken, bht_targ};
            n_checks++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL bht_access_unexpected: got we=%0b clr=%0b idx=%0h dom=%0d taken=%0b targ=%08h",
                         mon_act.we, mon_act.clr, mon_act.idx, mon_act.dom, mon_act.taken, mon_act.targ);
            end else begin
                mon_exp = exp_q.pop_front();
                if (mon_act !== mon_exp) begin
                    n_fail++;
                    $display("FAIL bht_access: got we=%0b clr=%0b idx=%0h dom=%0d taken=%0b targ=%08h expected we=%0b clr=%0b idx=%0h dom=%0d taken=%0b targ=%08h",
                             mon_act.we, mon_act.clr, mon_act.idx, mon_act.dom, mon_act.taken, mon_act.targ,
                             mon_exp.we, mon_exp.clr, mon_exp.idx, mon_exp.dom, mon_exp.taken, mon_exp.targ);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0;
        set_idle();
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_bht_req",   bht_req, 0);
        chk("rst_bht_we",    bht_we, 0);
        chk("rst_bht_clr",   bht_clr, 0);
        chk("rst_bht_idx",   bht_idx, 0);
        chk("rst_rsp_valid", lkp_rsp_valid, 0);
        chk("rst_busy",      flush_busy, 0);
        chk("rst_done",      flush_done, 0);
        next_cycle();
        rst_n = 1'b1;
        @(negedge clk);
        chk("idle_upd_ready", upd_ready, 1);

        // ---------------- Lookup only (0x12 truncated to 4 bits) --------
        next_cycle();
        set_lkp(4'h2, DOM_PRIV); exp_rd(4'h2, DOM_PRIV);
        @(negedge clk);
        chk("lkp_ready", lkp_ready, 1);
        chk("lkp_rsp_not_yet", lkp_rsp_valid, 0);
        next_cycle(); set_idle();
        @(negedge clk);
        chk("lkp_rsp_valid", lkp_rsp_valid, 1);
        next_cycle();
        @(negedge clk);
        chk("lkp_rsp_one_cycle", lkp_rsp_valid, 0);

        // ---------------- Starvation ------------------------------------
        next_cycle();
        set_upd(4'd5, 1'b1, 32'h0000_4450, DOM_PRIV);
        set_lkp(4'd0, DOM_USER); exp_rd(4'd0, DOM_USER);
        @(negedge clk);
        chk("starve_upd_ready", upd_ready, 1);
        for (int k = 1; k <= 7; k++) begin
            next_cycle();
            upd_valid = 1'b0;
            set_lkp(IDX_W'(k), DOM_USER); exp_rd(IDX_W'(k), DOM_USER);
            @(negedge clk);
            chk("starve_lkp_granted", lkp_ready, 1);
        end
        next_cycle();
        set_lkp(4'd8, DOM_USER);
        exp_wr(4'd5, DOM_PRIV, 1'b1, 32'h0000_4450);
        @(negedge clk);
        chk("starve_lkp_stalled", lkp_ready, 0);
        chk("starve_write", bht_we, 1);
        chk("starve_rsp_prev", lkp_rsp_valid, 1);
        next_cycle();
        set_lkp(4'd9, DOM_USER); exp_rd(4'd9, DOM_USER);
        @(negedge clk);
        chk("starve_lkp_resume", lkp_ready, 1);
        chk("starve_rsp_after_stall", lkp_rsp_valid, 0);
        next_cycle(); set_idle();

        // ---------------- FIFO full -------------------------------------
        for (int k = 0; k < 4; k++) begin
            next_cycle();
            set_upd(IDX_W'(8 + k), k[0], 32'hA000_0000 + k, DOM_PRIV);
            set_lkp(IDX_W'(k + 1), DOM_PRIV); exp_rd(IDX_W'(k + 1), DOM_PRIV);
            @(negedge clk);
            chk("full_fill_upd_ready", upd_ready, 1);
        end
        next_cycle();
        set_upd(4'd12, 1'b1, 32'hBBBB_0000, DOM_PRIV);
        set_lkp(4'd7, DOM_PRIV);
        exp_wr(4'd8, DOM_PRIV, 1'b0, 32'hA000_0000);
        @(negedge clk);
        chk("full_upd_ready_low", upd_ready, 0);
        chk("full_lkp_stalled", lkp_ready, 0);
        next_cycle(); set_idle();
        exp_wr(4'd9,  DOM_PRIV, 1'b1, 32'hA000_0001);
        exp_wr(4'd10, DOM_PRIV, 1'b0, 32'hA000_0002);
        exp_wr(4'd11, DOM_PRIV, 1'b1, 32'hA000_0003);
        @(negedge clk);
        chk("full_after_deq_ready", upd_ready, 1);
        repeat (4) next_cycle();

`ifdef BHT_CTRL_FLUSH_EN
        // ---------------- Flush USER ------------------------------------
        next_cycle();
        set_upd(4'd1, 1'b1, 32'h0000_0011, DOM_PRIV);
        set_lkp(4'hA, DOM_USER); exp_rd(4'hA, DOM_USER);
        next_cycle();
        set_upd(4'd2, 1'b0, 32'h0000_0022, DOM_USER);
        set_lkp(4'hB, DOM_USER); exp_rd(4'hB, DOM_USER);
        next_cycle();
        set_upd(4'd3, 1'b1, 32'h0000_0033, DOM_PRIV);
        set_lkp(4'hC, DOM_USER); exp_rd(4'hC, DOM_USER);
        next_cycle();
        upd_valid = 1'b0;
        flush_req = 1'b1; flush_dom = DOM_USER;
        set_lkp(4'hD, DOM_USER); exp_rd(4'hD, DOM_USER);
        for (int w = 0; w < 16; w++) exp_clr(IDX_W'(w), DOM_USER);
        @(negedge clk);
        chk("flush_req_cycle_lkp", lkp_ready, 1);
        chk("flush_req_cycle_busy", flush_busy, 0);
        for (int w = 0; w < 16; w++) begin
            next_cycle();
            flush_req = (w == 3);
            flush_dom = DOM_PRIV;
            set_upd(4'hF, 1'b1, 32'hDEAD_0000, DOM_USER);
            set_lkp(4'hE, DOM_PRIV);
            @(negedge clk);
            chk("walk_busy", flush_busy, 1);
            chk("walk_lkp_ready", lkp_ready, 0);
            chk("walk_upd_ready", upd_ready, 0);
            chk("walk_done_low", flush_done, 0);
        end
        next_cycle(); set_idle();
        exp_wr(4'd1, DOM_PRIV, 1'b1, 32'h0000_0011);
        exp_wr(4'd3, DOM_PRIV, 1'b1, 32'h0000_0033);
        @(negedge clk);
        chk("flush_done_pulse", flush_done, 1);
        chk("flush_done_busy", flush_busy, 0);
        chk("flush_done_rsp", lkp_rsp_valid, 0);
        next_cycle();
        @(negedge clk);
        chk("flush_done_one_cycle", flush_done, 0);
        repeat (3) next_cycle();

        // ---------------- Reset mid-walk --------------------------------
        next_cycle();
        flush_req = 1'b1; flush_dom = DOM_PRIV;
        for (int w = 0; w < 6; w++) begin
            next_cycle();
            flush_req = 1'b0;
            exp_clr(IDX_W'(w), DOM_PRIV);
        end
        next_cycle();
        rst_n = 1'b0;
        @(negedge clk);
        chk("rstwalk_bht_req", bht_req, 0);
        chk("rstwalk_bht_clr", bht_clr, 0);
        chk("rstwalk_bht_idx", bht_idx, 0);
        chk("rstwalk_busy", flush_busy, 0);
        chk("rstwalk_done", flush_done, 0);
        next_cycle(); next_cycle();
        rst_n = 1'b1;
        seen_flag = 1'b0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (flush_done || flush_busy) seen_flag = 1'b1;
        end
        chk("rstwalk_no_done_after", seen_flag, 0);
        next_cycle();
        set_lkp(4'd6, DOM_PRIV); exp_rd(4'd6, DOM_PRIV);
        @(negedge clk);
        chk("rstwalk_idle_lkp", lkp_ready, 1);
        next_cycle(); set_idle();

        // ---------------- Flush INIT: no walk ---------------------------
        next_cycle();
        flush_req = 1'b1; flush_dom = DOM_INIT;
        @(negedge clk);
        chk("init_done_same", flush_done, 0);
        next_cycle(); set_idle();
        @(negedge clk);
        chk("init_done_next", flush_done, 1);
        chk("init_busy", flush_busy, 0);
        next_cycle();
        @(negedge clk);
        chk("init_done_drop", flush_done, 0);
`else
        // ---------------- Flush support not built -----------------------
        next_cycle();
        set_upd(4'd2, 1'b0, 32'h0000_0022, DOM_USER);
        set_lkp(4'hA, DOM_USER); exp_rd(4'hA, DOM_USER);
        next_cycle();
        upd_valid = 1'b0;
        flush_req = 1'b1; flush_dom = DOM_USER;
        set_lkp(4'hB, DOM_USER); exp_rd(4'hB, DOM_USER);
        @(negedge clk);
        chk("nf_done_same", flush_done, 0);
        chk("nf_busy_same", flush_busy, 0);
        next_cycle(); set_idle();
        exp_wr(4'd2, DOM_USER, 1'b0, 32'h0000_0022);
        @(negedge clk);
        chk("nf_done_next", flush_done, 1);
        chk("nf_busy_next", flush_busy, 0);
        chk("nf_no_clear", bht_clr, 0);
        next_cycle();
        @(negedge clk);
        chk("nf_done_drop", flush_done, 0);
`endif

        repeat (3) next_cycle();
        @(negedge clk);
        chk("sb_pending", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
